prv32_bus_fabric: RTL and testbench
===================================

// Module: prv32_bus_fabric
// PURPOSE
//  Parametrised interconnect between the picorv32 native memory bus and NUM_SLAVES peripherals.
//  Replaces the fixed decoder and OR-reduced ready/rdata with a registered mask/base decode and a select-driven response mux.
//  Adds a per-access timeout and a bus-error response, so an unmapped or hung access cannot stall the CPU.
// PARAMETERS
//  NUM_SLAVES      8             number of slave ports (1..16)
//  SLAVE_BASE      {N{32'h0}}    packed N*32; slot i = base address of slave i
//  SLAVE_MASK      {N{32'h0}}    packed N*32; slot i = compare mask (hit: (addr & mask) == base)
//  TIMEOUT_CYCLES  255           ACCESS cycles without s_ready before the fabric errors (>=1)
//  ERR_RDATA       32'hDEADBEEF  rdata returned on an error response
// PORTS
//  clk        in   1      CPU clock (CLOCK_100 domain)
//  resetn     in   1      asynchronous active-low reset
//  m_valid    in   1      CPU mem_valid
//  m_instr    in   1      CPU mem_instr (not decoded; forwarded unchanged)
//  m_addr     in   32     CPU mem_addr
//  m_wstrb    in   4      CPU mem_wstrb (0 = read)
//  m_ready    out  1      to CPU mem_ready
//  m_rdata    out  32     to CPU mem_rdata
//  s_valid    out  N      per-slave valid; slaves take addr, wdata and wstrb directly from the CPU
//  s_ready    in   N      per-slave ready
//  s_rdata    in   N*32   per-slave rdata, packed; slot i = slave i
//  bus_err    out  1      one-cycle pulse on each error response
// BEHAVIOUR
//  - Reset (async): state IDLE; m_ready, m_rdata, s_valid, bus_err = 0; select and timer cleared.
//  - FSM IDLE -> ACCESS | ERROR; ACCESS -> IDLE | ERROR; ERROR -> IDLE.
//  - IDLE: on m_valid, decode m_addr and register a one-hot sel.
//    - Multiple hits: the lowest index wins.
//    - Any hit: load timer = TIMEOUT_CYCLES and go to ACCESS.
//    - No hit: go to ERROR.
//  - ACCESS: s_valid = sel (exactly one bit set).
//    - When s_ready & sel != 0: m_ready = 1 and m_rdata = s_rdata[sel] in the same cycle (combinational), then go to IDLE.
//    - s_ready from unselected slaves is ignored.
//    - Latency = 1 decode cycle + slave latency.
//  - Timer: decrements in each ACCESS cycle without ready.
//    - Timer at 1 with no ready: go to ERROR; s_valid drops the next cycle.
//    - Ready in the same cycle the timer expires: ready wins, normal completion.
//  - ERROR: exactly one cycle with m_ready = 1, m_rdata = ERR_RDATA, bus_err = 1 and s_valid = 0, then IDLE.
//    - A write that errors is dropped; no slave sees it.
//  - m_rdata = 0 whenever m_ready = 0, so the fabric stays OR-safe with legacy glue.
//  - The CPU holds m_valid and m_addr until m_ready. The fabric samples addr only in IDLE, so mid-access address changes are ignored.
//  - m_valid deasserted during ACCESS (never done by the CPU): abort to IDLE with no response.
//  - resetn low mid-access: immediate IDLE; a slave still asserting s_ready afterwards is ignored.
// CONFIGURATION
//  PRV32_BUS_ERR_LOG_EN defined:
//    - Extra ports err_addr[31:0], err_wr (1 = write) and err_count[15:0].
//    - On each error: capture m_addr and |m_wstrb; err_count increments and saturates at 16'hFFFF.
//    - All three reset to 0.
//  PRV32_BUS_ERR_LOG_EN undefined:
//    - The ports are absent and no capture logic is built.
//    - bus_err and ERR_RDATA behaviour are unchanged.
// STRUCTURE
//  - prv32_bus_pkg: FSM state enum (IDLE/ACCESS/ERROR), default ERR_RDATA, DE10-Lite map base/mask constants
//    (SRAM, GPIO, UART_TX, UART_RX, TIMER, AUDIO, VIDEO).
//  - Sub-module prv32_addr_match: combinational N-way mask/base compare plus lowest-index priority encoder
//    -> one-hot sel and hit.
//  - Timer width is $clog2(TIMEOUT_CYCLES+1).
// TESTING
//  - Read, slave 2 (base 32'h0200_0000, mask 32'hFF00_0000), ready after 3 cycles, rdata 32'h1234_5678:
//    s_valid=3'b100 for 3 cycles, then m_ready=1 with m_rdata=32'h1234_5678; total latency 4 cycles.
//  - Write to unmapped 32'hF000_0000:
//    no s_valid ever; ERROR next cycle with m_ready=1, m_rdata=32'hDEADBEEF, bus_err=1.
//  - TIMEOUT_CYCLES=4, slave never ready:
//    s_valid high for exactly 4 cycles, then error response; err_count=1 and err_addr captured (with _EN).
//  - Slave ready in the exact timeout cycle:
//    normal response with slave rdata; bus_err stays 0.
//  - Overlapping slaves 0 and 3 both hit 32'h0000_0010:
//    only s_valid[0] asserted; s_ready[3] pulsed high is ignored.
//  - resetn low during ACCESS:
//    all outputs 0 immediately; the next access after release completes normally.

Source files
------------

// File: rtl/prv32_bus_pkg.sv
// Shared types and constants for the picorv32 bus fabric: FSM states, error data and the DE10-Lite address map.
package prv32_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERROR  = 2'd2
  } fabric_state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // DE10-Lite peripheral map (base / compare mask pairs)
  localparam logic [31:0] SRAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] SRAM_MASK    = 32'hFF00_0000;
  localparam logic [31:0] GPIO_BASE    = 32'h0100_0000;
  localparam logic [31:0] GPIO_MASK    = 32'hFFFF_FF00;
  localparam logic [31:0] UART_TX_BASE = 32'h0200_0000;
  localparam logic [31:0] UART_TX_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] UART_RX_BASE = 32'h0200_0004;
  localparam logic [31:0] UART_RX_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] TIMER_BASE   = 32'h0300_0000;
  localparam logic [31:0] TIMER_MASK   = 32'hFFFF_FF00;
  localparam logic [31:0] AUDIO_BASE   = 32'h0400_0000;
  localparam logic [31:0] AUDIO_MASK   = 32'hFFFF_0000;
  localparam logic [31:0] VIDEO_BASE   = 32'h0800_0000;
  localparam logic [31:0] VIDEO_MASK   = 32'hF800_0000;

endpackage

// File: rtl/prv32_addr_match.sv
// N-way mask/base address compare with lowest-index priority; produces a one-hot select and a hit flag.
module prv32_addr_match #(
  parameter int unsigned                  NUM_SLAVES = 8,
  parameter logic [NUM_SLAVES*32-1:0]     SLAVE_BASE = {NUM_SLAVES{32'h0000_0000}},
  parameter logic [NUM_SLAVES*32-1:0]     SLAVE_MASK = {NUM_SLAVES{32'h0000_0000}}
) (
  input  logic [31:0]           addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  hit
);

  logic [NUM_SLAVES-1:0] raw_hit_s;

  // Raw per-slave compare, then keep only the lowest matching index
  always_comb begin
    raw_hit_s = {NUM_SLAVES{1'b0}};
    sel       = {NUM_SLAVES{1'b0}};
    hit       = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      raw_hit_s[i] = ((addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]);
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (raw_hit_s[i] && !hit) begin
        sel[i] = 1'b1;
        hit    = 1'b1;
      end else begin
        sel[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/prv32_bus_fabric.sv
// picorv32 native-bus interconnect with registered decode, select-driven response mux, timeout and bus error.
// Optional error logging (err_addr / err_wr / err_count) is built when PRV32_BUS_ERR_LOG_EN is defined.
module prv32_bus_fabric
  import prv32_bus_pkg::*;
#(
  parameter int unsigned              NUM_SLAVES     = 8,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {NUM_SLAVES{32'h0000_0000}},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = {NUM_SLAVES{32'h0000_0000}},
  parameter int unsigned              TIMEOUT_CYCLES = 255,
  parameter logic [31:0]              ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     m_valid,
  input  logic                     m_instr,
  input  logic [31:0]              m_addr,
  input  logic [3:0]               m_wstrb,
  output logic                     m_ready,
  output logic [31:0]              m_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
`ifdef PRV32_BUS_ERR_LOG_EN
  output logic [31:0]              err_addr,
  output logic                     err_wr,
  output logic [15:0]              err_count,
`endif
  output logic                     bus_err
);

  localparam int unsigned     TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TIMER_LOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TIMER_ONE  = TW'(1);

  fabric_state_e         state_r;
  fabric_state_e         state_nx_s;
  logic [NUM_SLAVES-1:0] sel_r;
  logic [TW-1:0]         timer_r;
  logic [NUM_SLAVES-1:0] match_sel_s;
  logic                  match_hit_s;
  logic                  ready_hit_s;
  logic [31:0]           slave_rdata_s;
  logic                  unused_s;

  // m_instr is carried to the slaves by the CPU wiring, not decoded here
  assign unused_s = ^{m_instr, m_wstrb};

  prv32_addr_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_addr_match (
    .addr (m_addr),
    .sel  (match_sel_s),
    .hit  (match_hit_s)
  );

  assign ready_hit_s = |(s_ready & sel_r);

  // Select-driven response mux; unselected slaves contribute nothing
  always_comb begin
    slave_rdata_s = 32'h0000_0000;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_r[i]) begin
        slave_rdata_s = slave_rdata_s | s_rdata[i*32 +: 32];
      end else begin
        slave_rdata_s = slave_rdata_s;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (m_valid) begin
          state_nx_s = match_hit_s ? ST_ACCESS : ST_ERROR;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!m_valid || ready_hit_s) begin
          state_nx_s = ST_IDLE;
        end else if (timer_r <= TIMER_ONE) begin
          state_nx_s = ST_ERROR;
        end else begin
          state_nx_s = ST_ACCESS;
        end
      end
      ST_ERROR: state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Select capture and access timer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_r   <= {NUM_SLAVES{1'b0}};
      timer_r <= {TW{1'b0}};
    end else if (state_r == ST_IDLE && m_valid) begin
      sel_r   <= match_sel_s;
      timer_r <= TIMER_LOAD;
    end else if (state_r == ST_ACCESS && !ready_hit_s) begin
      sel_r   <= sel_r;
      timer_r <= timer_r - TIMER_ONE;
    end else begin
      sel_r   <= sel_r;
      timer_r <= timer_r;
    end
  end

  // Output logic; m_rdata is forced to zero whenever m_ready is low
  always_comb begin
    s_valid = {NUM_SLAVES{1'b0}};
    m_ready = 1'b0;
    m_rdata = 32'h0000_0000;
    bus_err = 1'b0;
    case (state_r)
      ST_IDLE: begin
        m_ready = 1'b0;
      end
      ST_ACCESS: begin
        s_valid = sel_r;
        if (m_valid && ready_hit_s) begin
          m_ready = 1'b1;
          m_rdata = slave_rdata_s;
        end else begin
          m_ready = 1'b0;
        end
      end
      ST_ERROR: begin
        m_ready = 1'b1;
        m_rdata = ERR_RDATA;
        bus_err = 1'b1;
      end
      default: begin
        m_ready = 1'b0;
      end
    endcase
  end

`ifdef PRV32_BUS_ERR_LOG_EN
  logic [31:0] err_addr_r;
  logic        err_wr_r;
  logic [15:0] err_count_r;

  // Error log: the CPU still holds addr/wstrb during the error cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_addr_r  <= 32'h0000_0000;
      err_wr_r    <= 1'b0;
      err_count_r <= 16'h0000;
    end else if (state_r == ST_ERROR) begin
      err_addr_r  <= m_addr;
      err_wr_r    <= |m_wstrb;
      err_count_r <= (err_count_r == 16'hFFFF) ? err_count_r : err_count_r + 16'h0001;
    end else begin
      err_addr_r  <= err_addr_r;
      err_wr_r    <= err_wr_r;
      err_count_r <= err_count_r;
    end
  end

  assign err_addr  = err_addr_r;
  assign err_wr    = err_wr_r;
  assign err_count = err_count_r;
`endif

endmodule

// File: tb/tb_prv32_bus_fabric.sv
// Directed bench for prv32_bus_fabric: 4 slaves (0 and 3 overlap at low addresses), timeout of 4 cycles.
module tb_prv32_bus_fabric;

  localparam int unsigned N = 4;

  logic           clk;
  logic           resetn;
  logic           m_valid;
  logic           m_instr;
  logic [31:0]    m_addr;
  logic [3:0]     m_wstrb;
  logic           m_ready;
  logic [31:0]    m_rdata;
  logic [N-1:0]   s_valid;
  logic [N-1:0]   s_ready;
  logic [N*32-1:0] s_rdata;
  logic           bus_err;
`ifdef PRV32_BUS_ERR_LOG_EN
  logic [31:0]    err_addr;
  logic           err_wr;
  logic [15:0]    err_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  prv32_bus_fabric #(
    .NUM_SLAVES     (N),
    .SLAVE_BASE     ({32'h0000_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000}),
    .SLAVE_MASK     ({32'hFFFF_F000, 32'hFF00_0000, 32'hFF00_0000, 32'hFFFF_FF00}),
    .TIMEOUT_CYCLES (4),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .m_valid   (m_valid),
    .m_instr   (m_instr),
    .m_addr    (m_addr),
    .m_wstrb   (m_wstrb),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
`ifdef PRV32_BUS_ERR_LOG_EN
    .err_addr  (err_addr),
    .err_wr    (err_wr),
    .err_count (err_count),
`endif
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_resp(input string tag, input logic rdy, input logic [31:0] rd,
                          input logic err, input logic [N-1:0] sv);
    #1;
    chk({tag, ".m_ready"}, {31'd0, m_ready}, {31'd0, rdy});
    chk({tag, ".m_rdata"}, m_rdata, rd);
    chk({tag, ".bus_err"}, {31'd0, bus_err}, {31'd0, err});
    chk({tag, ".s_valid"}, {28'd0, s_valid}, {28'd0, sv});
  endtask

  initial begin
    resetn  = 1'b0;
    m_valid = 1'b0;
    m_instr = 1'b0;
    m_addr  = 32'h0000_0000;
    m_wstrb = 4'h0;
    s_ready = 4'b0000;
    s_rdata = {32'h3333_3333, 32'h1234_5678, 32'h0BAD_F00D, 32'hCAFE_0000};

    // Reset state
    tick();
    chk_resp("reset", 1'b0, 32'h0, 1'b0, 4'b0000);
    tick();
    resetn = 1'b1;

    // Read from slave 2, ready on the third access cycle
    tick();
    m_valid = 1'b1; m_addr = 32'h0200_0010; m_wstrb = 4'h0;
    chk_resp("rd2.decode", 1'b0, 32'h0, 1'b0, 4'b0000);
    tick(); chk_resp("rd2.acc1", 1'b0, 32'h0, 1'b0, 4'b0100);
    tick(); chk_resp("rd2.acc2", 1'b0, 32'h0, 1'b0, 4'b0100);
    tick(); s_ready = 4'b0100;
    chk_resp("rd2.done", 1'b1, 32'h1234_5678, 1'b0, 4'b0100);
    tick(); m_valid = 1'b0; s_ready = 4'b0000;
    chk_resp("rd2.idle", 1'b0, 32'h0, 1'b0, 4'b0000);

    // Write to unmapped address: immediate error, no slave ever selected
    tick();
    m_valid = 1'b1; m_addr = 32'hF000_0000; m_wstrb = 4'hF;
    chk_resp("unmap.decode", 1'b0, 32'h0, 1'b0, 4'b0000);
    tick(); chk_resp("unmap.err", 1'b1, 32'hDEAD_BEEF, 1'b1, 4'b0000);
    tick(); m_valid = 1'b0; m_wstrb = 4'h0;
    chk_resp("unmap.idle", 1'b0, 32'h0, 1'b0, 4'b0000);
`ifdef PRV32_BUS_ERR_LOG_EN
    chk("unmap.err_addr", err_addr, 32'hF000_0000);
    chk("unmap.err_wr", {31'd0, err_wr}, 32'd1);
    chk("unmap.err_count", {16'd0, err_count}, 32'd1);
`endif

    // Slave 1 never ready: four access cycles, then error
    tick();
    m_valid = 1'b1; m_addr = 32'h0100_0000;
    chk_resp("tmo.decode", 1'b0, 32'h0, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      tick(); chk_resp("tmo.acc", 1'b0, 32'h0, 1'b0, 4'b0010);
    end
    tick(); chk_resp("tmo.err", 1'b1, 32'hDEAD_BEEF, 1'b1, 4'b0000);
    tick(); m_valid = 1'b0;
    chk_resp("tmo.idle", 1'b0, 32'h0, 1'b0, 4'b0000);
`ifdef PRV32_BUS_ERR_LOG_EN
    chk("tmo.err_addr", err_addr, 32'h0100_0000);
    chk("tmo.err_wr", {31'd0, err_wr}, 32'd0);
    chk("tmo.err_count", {16'd0, err_count}, 32'd2);
`endif

    // Ready arrives exactly in the expiring cycle: normal completion wins
    tick();
    m_valid = 1'b1; m_addr = 32'h0100_0004;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_resp("edge.acc", 1'b0, 32'h0, 1'b0, 4'b0010);
    end
    tick(); s_ready = 4'b0010;
    chk_resp("edge.done", 1'b1, 32'h0BAD_F00D, 1'b0, 4'b0010);
    tick(); m_valid = 1'b0; s_ready = 4'b0000;
    chk_resp("edge.after", 1'b0, 32'h0, 1'b0, 4'b0000);

    // Overlap: slaves 0 and 3 both hit, slave 0 wins; ready from 3 is ignored
    tick();
    m_valid = 1'b1; m_addr = 32'h0000_0010;
    tick(); s_ready = 4'b1000;
    chk_resp("ovl.ign3", 1'b0, 32'h0, 1'b0, 4'b0001);
    tick(); s_ready = 4'b0001;
    chk_resp("ovl.done", 1'b1, 32'hCAFE_0000, 1'b0, 4'b0001);
    tick(); m_valid = 1'b0; s_ready = 4'b0000;

    // Reset during access: outputs clear at once, next access completes
    tick();
    m_valid = 1'b1; m_addr = 32'h0200_0000;
    tick(); chk_resp("rst.acc", 1'b0, 32'h0, 1'b0, 4'b0100);
    s_ready = 4'b0100; resetn = 1'b0;
    chk_resp("rst.async", 1'b0, 32'h0, 1'b0, 4'b0000);
    tick(); chk_resp("rst.held", 1'b0, 32'h0, 1'b0, 4'b0000);
    resetn = 1'b1;
    chk_resp("rst.release", 1'b0, 32'h0, 1'b0, 4'b0000);
    tick(); chk_resp("rst.next", 1'b1, 32'h1234_5678, 1'b0, 4'b0100);
    tick(); m_valid = 1'b0; s_ready = 4'b0000;
    chk_resp("rst.idle", 1'b0, 32'h0, 1'b0, 4'b0000);
`ifdef PRV32_BUS_ERR_LOG_EN
    chk("rst.err_count", {16'd0, err_count}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
